// File: rtl/axi4_lite_lstm_seq_ctrl.sv
// AXI4-Lite control block for an LSTM core: parameter load strobes, input/output
// sample FIFOs, sticky overflow flags and a level interrupt.
module axi4_lite_lstm_seq_ctrl #(
  parameter int          DATA_WIDTH = 16,
  parameter int          LAYERS     = 4,
  parameter int          WEIGHTS    = 4,
  parameter int          X_DEPTH    = 16,
  parameter int          Y_DEPTH    = 16,
  parameter logic [31:0] VERSION    = 32'h0002_0000,
  localparam int         NUM_PARAMS = 4*LAYERS*WEIGHTS + 2*LAYERS,
  localparam int         PIDX_W     = $clog2(NUM_PARAMS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [31:0]           araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [PIDX_W-1:0]     param_idx,
  output logic [DATA_WIDTH-1:0] param_data,
  output logic                  param_valid,
  output logic [DATA_WIDTH-1:0] x_data,
  output logic                  x_valid,
  input  logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] y_data,
  input  logic                  y_valid,
  output logic                  irq
);

  localparam int          XA_W       = $clog2(X_DEPTH);
  localparam int          YA_W       = $clog2(Y_DEPTH);
  localparam logic [XA_W:0] X_FULL_CNT = (XA_W+1)'(X_DEPTH);
  localparam logic [YA_W:0] Y_FULL_CNT = (YA_W+1)'(Y_DEPTH);
  localparam logic [31:0] PARAM_BASE = 32'h100;
  localparam logic [31:0] PARAM_END  = PARAM_BASE + 32'(4*NUM_PARAMS);

  logic                  wr_hs, rd_hs;
  logic                  w_ctrl, w_xpush, w_param, w_ok;
  logic [31:0]           w_off;
  logic                  irq_en, flush_pend, ovf_clr;
  logic                  x_ovf, y_ovf;
  logic [31:0]           rd_val, status;
  logic                  rd_err;

  logic [DATA_WIDTH-1:0] x_mem [X_DEPTH];
  logic [XA_W-1:0]       x_wr, x_rd;
  logic [XA_W:0]         x_count;
  logic                  x_full, x_empty, x_push, x_pop;

  logic [DATA_WIDTH-1:0] y_mem [Y_DEPTH];
  logic [YA_W-1:0]       y_wr, y_rd;
  logic [YA_W:0]         y_count;
  logic                  y_full, y_empty, y_push, y_pop;

  logic                  unused_ok;
  assign unused_ok = ^{awprot, arprot, wstrb, w_off, wdata};

  assign awready = rst_n & awvalid & wvalid & ~bvalid;
  assign wready  = awready;
  assign wr_hs   = awready;
  assign arready = rst_n & ~rvalid;
  assign rd_hs   = arvalid & arready;

  assign w_off   = awaddr - PARAM_BASE;
  assign w_ctrl  = (awaddr == 32'h8);
  assign w_xpush = (awaddr == 32'hC);
  assign w_param = (awaddr >= PARAM_BASE) && (awaddr < PARAM_END) && (awaddr[1:0] == 2'b00);
  assign w_ok    = w_ctrl | w_xpush | w_param;
  assign ovf_clr = wr_hs & w_ctrl & wdata[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid      <= 1'b0;
      bresp       <= 2'b00;
      irq_en      <= 1'b0;
      flush_pend  <= 1'b0;
      param_valid <= 1'b0;
      param_idx   <= '0;
      param_data  <= '0;
    end else begin
      // flush lands one cycle after bvalid rises
      flush_pend  <= wr_hs & w_ctrl & wdata[2];
      param_valid <= wr_hs & w_param;
      if (wr_hs) begin
        bvalid <= 1'b1;
        bresp  <= w_ok ? 2'b00 : 2'b10;
        if (w_ctrl) irq_en <= wdata[0];
        if (w_param) begin
          param_idx  <= w_off[PIDX_W+1:2];
          param_data <= wdata[DATA_WIDTH-1:0];
        end
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // X FIFO: register writes in, core stream out
  assign x_full  = (x_count == X_FULL_CNT);
  assign x_empty = (x_count == '0);
  assign x_push  = wr_hs & w_xpush & ~x_full;
  assign x_valid = ~x_empty;
  assign x_pop   = x_valid & x_ready;
  assign x_data  = x_mem[x_rd];

  always_ff @(posedge clk) begin
    if (x_push) x_mem[x_wr] <= wdata[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_wr    <= '0;
      x_rd    <= '0;
      x_count <= '0;
    end else if (flush_pend) begin
      x_wr    <= '0;
      x_rd    <= '0;
      x_count <= '0;
    end else begin
      if (x_push) x_wr <= x_wr + XA_W'(1);
      if (x_pop)  x_rd <= x_rd + XA_W'(1);
      x_count <= x_count + (XA_W+1)'(x_push) - (XA_W+1)'(x_pop);
    end
  end

  // Y FIFO: core results in, Y_POP reads out; fullness uses the pre-pop count
  assign y_full  = (y_count == Y_FULL_CNT);
  assign y_empty = (y_count == '0);
  assign y_push  = y_valid & ~y_full;
  assign y_pop   = rd_hs & (araddr == 32'h10) & ~y_empty;

  always_ff @(posedge clk) begin
    if (y_push) y_mem[y_wr] <= y_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_wr    <= '0;
      y_rd    <= '0;
      y_count <= '0;
    end else if (flush_pend) begin
      y_wr    <= '0;
      y_rd    <= '0;
      y_count <= '0;
    end else begin
      if (y_push) y_wr <= y_wr + YA_W'(1);
      if (y_pop)  y_rd <= y_rd + YA_W'(1);
      y_count <= y_count + (YA_W+1)'(y_push) - (YA_W+1)'(y_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_ovf <= 1'b0;
      y_ovf <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wr_hs & w_xpush & x_full) x_ovf <= 1'b1;
      else if (ovf_clr)             x_ovf <= 1'b0;
      if (y_valid & y_full)         y_ovf <= 1'b1;
      else if (ovf_clr)             y_ovf <= 1'b0;
      irq <= irq_en & (~y_empty | x_ovf | y_ovf);
    end
  end

  assign status = {8'h00, 8'(y_count), 10'b0, y_ovf, x_ovf, y_empty, y_full, x_empty, x_full};

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (araddr)
      32'h0:   rd_val = VERSION;
      32'h4:   rd_val = status;
      32'h8:   rd_val = {31'b0, irq_en};
      32'h10: begin
        if (y_empty) rd_err = 1'b1;
        else         rd_val = 32'(y_mem[y_rd]);
      end
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else if (rd_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_val;
      rresp  <= rd_err ? 2'b10 : 2'b00;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_lstm_seq_ctrl.sv
// Bench for axi4_lite_lstm_seq_ctrl: queue-based reference model checked every
// cycle, directed register-map scenarios and a randomized transaction phase.
module tb_axi4_lite_lstm_seq_ctrl;
  localparam int DW = 16;
  localparam int NUM_PARAMS = 72;
  localparam int PIDX_W = 7;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic [PIDX_W-1:0] param_idx;
  logic [DW-1:0] param_data, x_data, y_data;
  logic param_valid, x_valid, x_ready, y_valid, irq;

  logic rand_en;
  int xr_thresh;
  logic x_ready_dir, x_ready_rnd, y_valid_dir, y_valid_rnd;
  logic [DW-1:0] y_data_dir, y_data_rnd;
  assign x_ready = rand_en ? x_ready_rnd : x_ready_dir;
  assign y_valid = rand_en ? y_valid_rnd : y_valid_dir;
  assign y_data  = rand_en ? y_data_rnd  : y_data_dir;

  int n_chk = 0;
  int n_fail = 0;

  axi4_lite_lstm_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .param_idx(param_idx), .param_data(param_data), .param_valid(param_valid),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] xq[$], yq[$];
  logic m_xovf, m_yovf, m_irq_en, m_irq, m_flush;
  logic m_bv, m_rv, m_pv;
  logic [1:0] m_bresp, m_rresp;
  logic [31:0] m_rdata;
  logic [PIDX_W-1:0] m_pidx;
  logic [DW-1:0] m_pdata;

  always @(posedge clk or negedge rst_n) begin
    int xn, yn, k;
    logic clr, setx, sety, fl, en_old, irq_next;
    if (!rst_n) begin
      xq.delete(); yq.delete();
      m_xovf = 0; m_yovf = 0; m_irq_en = 0; m_irq = 0; m_flush = 0;
      m_bv = 0; m_rv = 0; m_pv = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
      m_pidx = 0; m_pdata = 0;
    end else begin
      xn = xq.size(); yn = yq.size();
      en_old = m_irq_en;
      irq_next = m_irq_en && (yn != 0 || m_xovf || m_yovf);
      fl = m_flush; m_flush = 0; clr = 0; setx = 0; sety = 0; m_pv = 0;
      if (awvalid && wvalid && !m_bv) begin
        m_bv = 1; m_bresp = 2'b00;
        if (awaddr == 32'h8) begin
          m_irq_en = wdata[0]; clr = wdata[1]; m_flush = wdata[2];
        end else if (awaddr == 32'hC) begin
          if (xn < DEPTH) xq.push_back(wdata[DW-1:0]);
          else setx = 1;
        end else if (awaddr >= 32'h100 && awaddr < 32'h100 + 4*NUM_PARAMS && awaddr[1:0] == 2'b00) begin
          k = int'((awaddr - 32'h100) / 4);
          m_pv = 1; m_pidx = k[PIDX_W-1:0]; m_pdata = wdata[DW-1:0];
        end else m_bresp = 2'b10;
      end else if (m_bv && bready) m_bv = 0;
      if (arvalid && !m_rv) begin
        m_rv = 1; m_rresp = 2'b00; m_rdata = 0;
        case (araddr)
          32'h0: m_rdata = 32'h0002_0000;
          32'h4: m_rdata = (yn << 16) | (m_yovf << 5) | (m_xovf << 4) | ((yn == 0) << 3)
                           | ((yn == DEPTH) << 2) | ((xn == 0) << 1) | (xn == DEPTH);
          32'h8: m_rdata = {31'b0, en_old};
          32'h10: if (yn > 0) m_rdata = 32'(yq.pop_front()); else m_rresp = 2'b10;
          default: m_rresp = 2'b10;
        endcase
      end else if (m_rv && rready) m_rv = 0;
      if (y_valid) begin
        if (yn < DEPTH) yq.push_back(y_data);
        else sety = 1;
      end
      if (xn > 0 && x_ready) void'(xq.pop_front());
      if (clr) begin m_xovf = 0; m_yovf = 0; end
      if (setx) m_xovf = 1;
      if (sety) m_yovf = 1;
      if (fl) begin xq.delete(); yq.delete(); end
      m_irq = irq_next;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("x_valid", x_valid, xq.size() != 0);
      if (xq.size() != 0) chk("x_data", x_data, xq[0]);
      chk("irq", irq, m_irq);
      chk("param_valid", param_valid, m_pv);
      if (m_pv) begin
        chk("param_idx", param_idx, m_pidx);
        chk("param_data", param_data, m_pdata);
      end
      chk("awready", awready, awvalid && wvalid && !m_bv);
      chk("wready", wready, awvalid && wvalid && !m_bv);
      chk("arready", arready, !m_rv);
      chk("bvalid", bvalid, m_bv);
      if (m_bv) chk("bresp", bresp, m_bresp);
      chk("rvalid", rvalid, m_rv);
      if (m_rv) begin
        chk("rdata", rdata, m_rdata);
        chk("rresp", rresp, m_rresp);
      end
    end
  end

  // ---------------- monitors and random core-side driver ----------------
  int pv_cnt = 0;
  logic [PIDX_W-1:0] pv_idx;
  logic [DW-1:0] pv_data;
  logic [DW-1:0] drained[$];
  always @(negedge clk) begin
    if (rst_n && param_valid) begin pv_cnt++; pv_idx = param_idx; pv_data = param_data; end
    if (rst_n && x_valid && x_ready) drained.push_back(x_data);
  end

  initial begin
    x_ready_rnd = 0; y_valid_rnd = 0; y_data_rnd = 0;
    forever begin
      @(negedge clk);
      x_ready_rnd = ($urandom_range(0, 7) < xr_thresh);
      y_valid_rnd = ($urandom_range(0, 3) == 0);
      y_data_rnd  = DW'($urandom);
    end
  end

  // ---------------- AXI tasks ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid_wait", bvalid, 1'b1);
    resp = bresp;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rvalid_wait", rvalid, 1'b1);
    d = rdata; resp = rresp;
  endtask

  task automatic y_pulses(input int cnt, input int base);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      y_valid_dir = 1; y_data_dir = DW'(base + i);
    end
    @(negedge clk);
    y_valid_dir = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r;
    logic [31:0] d;
    logic [31:0] odd_addr [6];
    int n;
    odd_addr = '{32'h0, 32'h4, 32'h10, 32'hC0, 32'h101, 32'h21C};
    rst_n = 0; rand_en = 0; xr_thresh = 0;
    awaddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0; araddr = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    x_ready_dir = 0; y_valid_dir = 0; y_data_dir = 0;
    repeat (3) @(negedge clk);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1;

    axi_read(32'h0, d, r);
    chk("version_data", d, 32'h0002_0000);
    chk("version_resp", r, 2'b00);
    axi_read(32'h4, d, r);
    chk("status_after_reset", d, 32'h0000_000A);

    axi_write(32'h100 + 4*5, 32'h1234, r);
    chk("param_bresp", r, 2'b00);
    repeat (3) @(negedge clk);
    chk("param_pulse_count", pv_cnt, 1);
    chk("param_idx_lit", pv_idx, 5);
    chk("param_data_lit", pv_data, 16'h1234);

    for (int i = 0; i < 17; i++) begin
      axi_write(32'hC, 32'h100 + i, r);
      chk("xpush_bresp", r, 2'b00);
    end
    axi_read(32'h4, d, r);
    chk("status_x_full_ovf", d, 32'h0000_0019);
    drained.delete();
    @(negedge clk); x_ready_dir = 1;
    repeat (20) @(negedge clk);
    x_ready_dir = 0;
    chk("drain_count", drained.size(), 16);
    for (int i = 0; i < 16 && i < drained.size(); i++) chk("drain_order", drained[i], 32'h100 + i);
    axi_write(32'h8, 32'h2, r);
    axi_read(32'h4, d, r);
    chk("status_after_clr", d, 32'h0000_000A);

    axi_write(32'h8, 32'h1, r);
    y_pulses(1, 3);
    y_pulses(1, 7);
    repeat (2) @(negedge clk);
    chk("irq_set_lit", irq, 1'b1);
    axi_read(32'h4, d, r);
    chk("status_y_count2", d, 32'h0002_0002);
    axi_read(32'h10, d, r);
    chk("ypop_first", d, 3); chk("ypop_first_resp", r, 2'b00);
    axi_read(32'h10, d, r);
    chk("ypop_second", d, 7); chk("ypop_second_resp", r, 2'b00);
    axi_read(32'h10, d, r);
    chk("ypop_empty_data", d, 0); chk("ypop_empty_resp", r, 2'b10);
    repeat (2) @(negedge clk);
    chk("irq_clear_lit", irq, 1'b0);

    axi_write(32'hC0, 32'hFFFF_FFFF, r);
    chk("unmapped_bresp", r, 2'b10);
    axi_write(32'h4, 32'hFFFF_FFFF, r);
    chk("ro_bresp", r, 2'b10);
    axi_write(32'h100 + 4*NUM_PARAMS, 32'h55, r);
    chk("param_oob_bresp", r, 2'b10);
    axi_read(32'hC, d, r);
    chk("wo_read_resp", r, 2'b10); chk("wo_read_data", d, 0);
    axi_read(32'h4, d, r);
    chk("status_unchanged", d, 32'h0000_000A);
    axi_read(32'h8, d, r);
    chk("ctrl_readback", d, 32'h1);

    y_pulses(17, 32'h40);
    repeat (2) @(negedge clk);
    axi_read(32'h4, d, r);
    chk("status_y_full_ovf", d, 32'h0010_0026);
    axi_write(32'h8, 32'h4, r);
    repeat (2) @(negedge clk);
    axi_read(32'h4, d, r);
    chk("status_after_flush", d, 32'h0000_002A);
    axi_write(32'h8, 32'h2, r);
    axi_read(32'h4, d, r);
    chk("status_after_clr2", d, 32'h0000_000A);

    rand_en = 1;
    for (int i = 0; i < 300; i++) begin
      int sel;
      xr_thresh = (i < 150) ? 1 : 5;
      sel = $urandom_range(0, 9);
      case (sel)
        0: begin
          d = 32'($urandom_range(0, 3));
          if ($urandom_range(0, 9) == 0) d = d | 32'h4;
          axi_write(32'h8, d, r);
        end
        1, 2, 3: axi_write(32'hC, $urandom, r);
        4: axi_write(32'h100 + 32'(4*$urandom_range(0, NUM_PARAMS)), $urandom, r);
        5: axi_read(32'h4, d, r);
        6, 7: axi_read(32'h10, d, r);
        8: axi_read(($urandom_range(0, 1) == 0) ? 32'h0 : 32'h8, d, r);
        default: begin
          if ($urandom_range(0, 1) == 0) axi_read(odd_addr[$urandom_range(0, 5)], d, r);
          else axi_write(odd_addr[$urandom_range(0, 5)], $urandom, r);
        end
      endcase
    end
    rand_en = 0;
    repeat (3) @(negedge clk);

    axi_write(32'h8, 32'h1, r);
    axi_write(32'hC, 32'hAAAA, r);
    y_pulses(2, 5);
    @(negedge clk);
    araddr = 32'h0; arvalid = 1; rready = 0;
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("held_rvalid", rvalid, 1'b1);
    repeat (2) @(negedge clk);
    chk("held_rvalid_still", rvalid, 1'b1);
    rst_n = 0; arvalid = 1;
    #1;
    chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
    chk("rst_bvalid2", bvalid, 0);  chk("rst_arready", arready, 0);
    chk("rst_rvalid2", rvalid, 0);  chk("rst_param_valid", param_valid, 0);
    chk("rst_x_valid2", x_valid, 0); chk("rst_irq2", irq, 0);
    chk("rst_bresp", bresp, 0);     chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);     chk("rst_param_idx", param_idx, 0);
    chk("rst_param_data", param_data, 0);
    @(negedge clk);
    arvalid = 0; rready = 1;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_rvalid", rvalid, 0);
    axi_read(32'h4, d, r);
    chk("post_rst_status", d, 32'h0000_000A);
    axi_read(32'h8, d, r);
    chk("post_rst_ctrl", d, 32'h0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_lite_lstm_seq_ctrl.md
AXI4_LITE_LSTM_SEQ_CTRL -- requirements
Module: axi4_lite_lstm_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of LSTM parameters, inputs and outputs.
REQ-002 SHALL have parameter LAYERS, default 4: LSTM layer count.
REQ-003 SHALL have parameter WEIGHTS, default 4: gates per layer.
REQ-004 SHALL have parameter X_DEPTH, default 16 (power of 2): input FIFO depth.
REQ-005 SHALL have parameter Y_DEPTH, default 16 (power of 2): output FIFO depth.
REQ-006 SHALL have parameter VERSION, default 32'h0002_0000: VERSION register value.
REQ-007 SHALL define localparam NUM_PARAMS = 4*LAYERS*WEIGHTS + 2*LAYERS, and PIDX_W = $clog2(NUM_PARAMS).
REQ-008 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-009 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-010 SHALL have AXI4-Lite slave ports, AMBA-standard directions: awaddr[31:0], awprot[2:0], awvalid, awready, wdata[31:0], wstrb[3:0], wvalid, wready, bresp[1:0], bvalid, bready, araddr[31:0], arprot[2:0], arvalid, arready, rdata[31:0], rresp[1:0], rvalid, rready.
REQ-011 SHALL have ports param_idx  out  PIDX_W; param_data  out  DATA_WIDTH; param_valid  out  1: weight/bias/state load strobe to the core.
REQ-012 SHALL have ports x_data  out  DATA_WIDTH; x_valid  out  1; x_ready  in  1: input sample stream to the core.
REQ-013 SHALL have ports y_data  in  DATA_WIDTH; y_valid  in  1: core result, no backpressure.
REQ-014 SHALL have port irq  out  1: level interrupt.

Function
REQ-015 SHALL decode this register map (byte addresses, awprot/arprot/wstrb ignored): 0x00 VERSION RO; 0x04 STATUS RO; 0x08 CTRL RW; 0x0C X_PUSH WO; 0x10 Y_POP RO; 0x100+4k PARAM[k] WO, k<NUM_PARAMS.
REQ-016 Write handshake: awready = wready = awvalid & wvalid & ~bvalid; bvalid set on the cycle after the handshake, held until bready.
REQ-017 Read handshake: arready = rst_n & ~rvalid; rdata/rresp/rvalid registered one cycle after the handshake, held until rready.
REQ-018 Unmapped address, write to RO, or read of WO: bresp/rresp = 2'b10 (SLVERR), rdata = 0, no side effect.
REQ-019 PARAM[k] write: param_valid SHALL pulse one cycle, on the cycle after the handshake, with param_idx = k and param_data = wdata[DATA_WIDTH-1:0].
REQ-020 X_PUSH write: pushes wdata[DATA_WIDTH-1:0] into the X FIFO; if the X FIFO is full at the handshake, the push is dropped, STATUS.x_ovf is set and bresp = OKAY.
REQ-021 X FIFO head drives x_data; x_valid = ~x_empty; pop when x_valid & x_ready.
REQ-022 y_valid pushes y_data into the Y FIFO; if full, drop and set STATUS.y_ovf; this holds even if a pop occurs in the same cycle.
REQ-023 Y_POP read: pops at the AR handshake and returns the zero-extended head; on empty, rdata = 0, rresp = SLVERR, no pop.
REQ-024 Simultaneous push and pop on a non-full, non-empty FIFO SHALL both take effect, leaving the count unchanged.
REQ-025 STATUS SHALL read: [0] x_full, [1] x_empty, [2] y_full, [3] y_empty, [4] x_ovf, [5] y_ovf, [23:16] y_count; other bits 0.
REQ-026 CTRL SHALL read: [0] irq_en, RW; [1] ovf_clr, write 1 clears both ovf sticky bits; [2] flush, write 1 empties both FIFOs the cycle after bvalid rises. Bits [2:1] self-clear and read 0.
REQ-027 irq SHALL be registered: irq = irq_en & (~y_empty | x_ovf | y_ovf).

Reset
REQ-028 While rst_n is low: awready, wready, bvalid, arready, rvalid, param_valid, x_valid and irq = 0; bresp, rresp, rdata, param_idx and param_data = 0; FIFOs empty; CTRL and sticky bits = 0.
REQ-029 rst_n assertion mid-transaction SHALL abort it immediately; no pending bvalid or rvalid SHALL survive reset.

Verification
REQ-030 Read 0x00 after reset -> rdata = VERSION, rresp = 0, STATUS read = 0x0000_000A.
REQ-031 Write 0x100+4*5 with data 0x1234 -> one-cycle param_valid, param_idx = 5, param_data = 0x1234.
REQ-032 17 X_PUSH writes with x_ready = 0 (X_DEPTH = 16) -> x_full = 1, x_ovf = 1, the 17th value is dropped; then x_ready = 1 -> 16 values drain in order.
REQ-033 Core pulses y_valid with 3, 7 while irq_en = 1 -> irq = 1, y_count = 2; Y_POP reads return 3 then 7; a third read returns SLVERR; irq = 0.
REQ-034 Write to 0x0C0 (unmapped) and to 0x04 (RO) -> bresp = SLVERR, no state change.
REQ-035 Pulse rst_n low while rvalid is held with rready = 0 -> rvalid = 0, FIFOs empty, all outputs at their reset values.
